// File: rtl/alu_74181_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_74181_arbiter_if
// Bundles the two request channels, the result channel and the completed-
// operation counter of alu_74181_arbiter.
//   req0_*/req1_* : valid, a[3:0], b[3:0], s[3:0] in; ready out
//   res_*         : valid, f[3:0], id out; ready in
//   op_cnt        : CNT_W-bit count of consumed results
// slave  = arbiter side, master = requester/consumer side.
// ---------------------------------------------------------------------------
interface alu_74181_arbiter_if #(
   parameter int CNT_W = 8
);
   logic             req0_valid;
   logic [3:0]       req0_a;
   logic [3:0]       req0_b;
   logic [3:0]       req0_s;
   logic             req0_ready;
   logic             req1_valid;
   logic [3:0]       req1_a;
   logic [3:0]       req1_b;
   logic [3:0]       req1_s;
   logic             req1_ready;
   logic             res_valid;
   logic [3:0]       res_f;
   logic             res_id;
   logic             res_ready;
   logic [CNT_W-1:0] op_cnt;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_s,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_s,
      output req1_ready,
      output res_valid, res_f, res_id,
      input  res_ready,
      output op_cnt
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_s,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_s,
      input  req1_ready,
      input  res_valid, res_f, res_id,
      output res_ready,
      input  op_cnt
   );
endinterface

// File: rtl/alu_74181_arbiter.sv
// ---------------------------------------------------------------------------
// alu_74181_arbiter
// Shares one 4-bit 74181 logic unit (M=1, 16 functions) between two
// requesters with round-robin arbitration and a single-entry result slot.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_74181_arbiter_if.slave (requests, result, op_cnt)
// The result slot accepts a new operation when empty, or in the same cycle
// the held result is consumed, so back-to-back traffic runs without bubbles.
// ---------------------------------------------------------------------------
module alu_74181_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_74181_arbiter_if.slave    bus
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             last_r;       // index of the last granted requester
   logic [3:0]       res_f_r;
   logic             res_id_r;
   logic [CNT_W-1:0] op_cnt_r;

   logic             slot_open_s;
   logic             rdy0_s;
   logic             rdy1_s;
   logic             accept_s;
   logic             xfer_s;
   logic [3:0]       op_a_s;
   logic [3:0]       op_b_s;
   logic [3:0]       op_s_s;

   // 74181 logic-mode function table (active-high data, M=1)
   function automatic logic [3:0] lu_74181(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [3:0] s);
      logic [3:0] f;
      case (s)
         4'b0000: f = ~a;
         4'b0001: f = ~(a | b);
         4'b0010: f = ~a & b;
         4'b0011: f = 4'b0000;
         4'b0100: f = ~(a & b);
         4'b0101: f = ~b;
         4'b0110: f = a ^ b;
         4'b0111: f = a & ~b;
         4'b1000: f = ~a | b;
         4'b1001: f = ~(a ^ b);
         4'b1010: f = b;
         4'b1011: f = a & b;
         4'b1100: f = 4'b1111;
         4'b1101: f = a | ~b;
         4'b1110: f = a | b;
         4'b1111: f = a;
         default: f = 4'b0000;
      endcase
      return f;
   endfunction

   assign xfer_s      = (state_r == ST_FULL) && bus.res_ready;
   assign slot_open_s = (state_r == ST_EMPTY) || bus.res_ready;
   assign accept_s    = rdy0_s || rdy1_s;

   // Round-robin grant; ties go to the requester not granted last
   always_comb begin
      rdy0_s = 1'b0;
      rdy1_s = 1'b0;
      if (rst || !slot_open_s) begin
         rdy0_s = 1'b0;
         rdy1_s = 1'b0;
      end else if (bus.req0_valid && bus.req1_valid) begin
         rdy0_s = last_r;
         rdy1_s = ~last_r;
      end else begin
         rdy0_s = bus.req0_valid;
         rdy1_s = bus.req1_valid;
      end
   end

   // Operand mux feeding the shared logic unit
   always_comb begin
      op_a_s = 4'b0000;
      op_b_s = 4'b0000;
      op_s_s = 4'b0000;
      if (rdy1_s) begin
         op_a_s = bus.req1_a;
         op_b_s = bus.req1_b;
         op_s_s = bus.req1_s;
      end else begin
         op_a_s = bus.req0_a;
         op_b_s = bus.req0_b;
         op_s_s = bus.req0_s;
      end
   end

   // Slot next-state: accept always leaves it FULL, a bare transfer empties it
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               state_nxt_s = ST_FULL;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (xfer_s && !accept_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Result slot and grant pointer; a reset drops any pending result
   always_ff @(posedge clk) begin
      if (rst) begin
         res_f_r  <= 4'b0000;
         res_id_r <= 1'b0;
         last_r   <= 1'b1;
      end else if (accept_s) begin
         res_f_r  <= lu_74181(op_a_s, op_b_s, op_s_s);
         res_id_r <= rdy1_s;
         last_r   <= rdy1_s;
      end
   end

   // Consumed-result counter, wraps naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         op_cnt_r <= '0;
      end else if (xfer_s) begin
         op_cnt_r <= op_cnt_r + CNT_W'(1);
      end
   end

   assign bus.req0_ready = rdy0_s;
   assign bus.req1_ready = rdy1_s;
   assign bus.res_valid  = (state_r == ST_FULL);
   assign bus.res_f      = res_f_r;
   assign bus.res_id     = res_id_r;
   assign bus.op_cnt     = op_cnt_r;

endmodule

// File: doc/alu_74181_arbiter.md
ALU_74181_ARBITER -- requirements
Module: alu_74181_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of the completed-operation counter.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_a, req0_b, req0_s  input  4 each  requester 0 operands and 74181 logic select.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_s, req1_ready  same widths and meanings as REQ-004..006, for requester 1.
REQ-008 res_valid  output  1  result register holds a valid result.
REQ-009 res_f  output  4  logic result.
REQ-010 res_id  output  1  requester that issued the result (0 or 1).
REQ-011 res_ready  input  1  consumer accepts the result this cycle.
REQ-012 op_cnt  output  CNT_W  count of results consumed since reset.

Function
REQ-013 The block SHALL own one instance of the team's 4-bit 74181 logic-function unit (16 functions selected by s, M=1 mode) and share it between the two requesters.
REQ-014 Transfers SHALL be valid/ready: a request transfers in a cycle where reqN_valid and reqN_ready are both 1; a result transfers where res_valid and res_ready are both 1.
REQ-015 State machine: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-016 The block SHALL be able to accept ("slot open") when state is EMPTY, or when FULL with res_ready=1 in the same cycle (pass-through, zero bubble).
REQ-017 At most one reqN_ready SHALL be 1 per cycle; reqN_ready SHALL be 0 when the slot is not open or reqN_valid=0.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant goes to the requester not granted last; with one valid, it is granted regardless of history.
REQ-019 The last-grant pointer SHALL update only on an accepted request.
REQ-020 On accept, res_f SHALL load f computed from the granted a, b, s in that cycle, res_id SHALL load the granted index, and state SHALL be FULL next cycle (latency 1 cycle).
REQ-021 Transitions: EMPTY->FULL on accept; FULL->EMPTY on result transfer without accept; FULL->FULL on hold (res_ready=0) or on transfer with accept.
REQ-022 While FULL and res_ready=0, res_f and res_id SHALL remain stable and both reqN_ready SHALL be 0.
REQ-023 op_cnt SHALL increment by 1 on each result transfer, wrapping from 2^CNT_W-1 to 0.
REQ-024 reqN_ready SHALL depend combinationally on reqN_valid, res_ready, state and pointer only; no combinational path from a, b, s to any output.

Reset
REQ-025 While rst=1 at a clock edge: state EMPTY, res_valid=0, res_f=0000, res_id=0, op_cnt=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-026 reqN_ready SHALL be 0 in any cycle where rst=1.
REQ-027 Reset asserted while FULL SHALL discard the pending result without a transfer and without incrementing op_cnt.

Verification
REQ-028 After reset, req0 only: s=0110, a=1010, b=0110 -> next cycle res_valid=1, res_f=1100, res_id=0; on res_ready op_cnt=1.
REQ-029 Both valid every cycle, res_ready=1 held: req0 s=0000 a=0011, req1 s=1011 a=1100 b=1010 -> results alternate id 0 (f=1100), id 1 (f=1000), one per cycle, no bubbles.
REQ-030 Backpressure: FULL with res_ready=0 for 3 cycles -> res_f/res_id stable, both ready=0; release -> result transfers, pending request accepted same cycle.
REQ-031 All 16 s values with a=1010, b=1100 through req1 -> res_f matches the 74181 logic table for each (e.g., s=0011 -> 0000, s=1100 -> 1111, s=1111 -> 1010).
REQ-032 Reset asserted in FULL state -> next cycle res_valid=0, op_cnt=0, first tie then goes to req0.
REQ-033 2^CNT_W+1 consumed results (CNT_W=8: 257) -> op_cnt=1 (wrap).
